muldiv_hilo_unit: RTL and testbench

- Multi-cycle MULTU/DIVU engine for the 5-stage MIPS pipeline; owns the HI/LO registers.
- Consumes operands and op code from the ID/EX register outputs.
- Drives the `en_reg` pipeline-enable that holds IF/ID and ID/EX while an operation is in flight and a dependent instruction tries to issue.
- Results feed the MFHI/MFLO path into the EX-stage result mux.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_hilo_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the HI/LO multiply/divide unit
// Purpose: op codes seen on the ID/EX op field, FSM state encoding and the
//          divide-by-zero LO result.
// Ports:   none (package).
package muldiv_pkg;

  // Op field from ID/EX; 2'b11 is also treated as "no operation".
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MULT = 2'b01,
    OP_DIV  = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  // LO after a divide by zero is all ones; slice to the operand width.
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-divide iteration
// Purpose: single iteration of the multiply or divide loop.
// Ports:   is_div   - 1 selects the restoring divide step, 0 the shift-add step
//          acc      - MULT: {partial product, remaining multiplier bits}
//                     DIV:  {remainder, dividend/quotient bits}
//          opnd     - multiplicand (MULT) or divisor (DIV)
//          acc_next - accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub_diff;

  always_comb begin
    // Upper half plus multiplicand needs WIDTH+1 bits; the carry becomes the
    // new MSB once the accumulator shifts right.
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // {rem, quo} shifted left by one: the remainder gains the quotient MSB.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    // Only used when rem_sh >= opnd, so the difference always fits WIDTH bits.
    sub_diff = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      if (rem_sh >= {1'b0, opnd}) begin
        acc_next = {sub_diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - multi-cycle MULT/DIV engine owning the HI/LO registers
// Purpose: accepts MULT/DIV from ID/EX, iterates one bit per cycle, writes
//          HI/LO and stalls HI/LO users while busy. Optional macro
//          MULDIV_SIGNED_EN enables signed operation via signed_op.
// Ports:   clk, reset          - clock, synchronous active-high reset
//          op, signed_op       - ID/EX op (01 MULT, 10 DIV) and signed variant
//          src_a, src_b        - rs / rt operands
//          rd_hilo, wr_hi/lo   - MFHI/MFLO, MTHI, MTLO in EX
//          hi, lo              - HI/LO registers
//          busy, done          - FSM not idle; one-cycle pulse in FIX
//          en_reg              - IF/ID and ID/EX enable, 0 = stall
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hilo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             en_reg
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               is_div;
  logic               div0;
  logic               use_hilo;

  assign use_hilo = (op != OP_NONE) || rd_hilo || wr_hi || wr_lo;
  assign busy     = (state != IDLE);
  assign en_reg   = ~(busy & use_hilo);

`ifdef MULDIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_q;
  logic neg_r;

  assign neg_a = signed_op & src_a[WIDTH-1];
  assign neg_b = signed_op & src_b[WIDTH-1];
  assign a_mag = neg_a ? -src_a : src_a;
  assign b_mag = neg_b ? -src_b : src_b;

  // Result sign flags: product/quotient negate on differing signs,
  // remainder follows the dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && (op == OP_MULT || op == OP_DIV)) begin
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
    end
  end

  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    // Divide by zero already holds the raw dividend and all-ones LO.
    if (!div0) begin
      if (is_div) begin
        if (neg_q) res_lo = -acc[WIDTH-1:0];
        if (neg_r) res_hi = -acc[2*WIDTH-1:WIDTH];
      end else if (neg_q) begin
        {res_hi, res_lo} = -acc;
      end
    end
  end
`else
  logic unused_inputs;

  // Unsigned-only build: signed_op is ignored and the div0 result needs no
  // special handling in FIX.
  assign unused_inputs = signed_op ^ div0;
  assign a_mag  = src_a;
  assign b_mag  = src_b;
  assign res_hi = acc[2*WIDTH-1:WIDTH];
  assign res_lo = acc[WIDTH-1:0];
`endif

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (op == OP_MULT) begin
            opnd   <= a_mag;
            acc    <= {{WIDTH{1'b0}}, b_mag};
            is_div <= 1'b0;
            div0   <= 1'b0;
            state  <= RUN;
          end else if (op == OP_DIV) begin
            is_div <= 1'b1;
            if (src_b == '0) begin
              // Park the final result in acc so FIX just copies it out.
              acc   <= {src_a, DIV0_LO[WIDTH-1:0]};
              div0  <= 1'b1;
              done  <= 1'b1;
              state <= FIX;
            end else begin
              opnd  <= b_mag;
              acc   <= {{WIDTH{1'b0}}, a_mag};
              div0  <= 1'b0;
              state <= RUN;
            end
          end else begin
            if (wr_hi) hi <= src_a;
            if (wr_lo) lo <= src_a;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            done  <= 1'b1;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - self-checking bench for muldiv_hilo_unit
module tb_muldiv_hilo_unit;

  localparam logic [1:0] T_MULT = 2'b01;
  localparam logic [1:0] T_DIV  = 2'b10;

  logic        clk;
  logic        reset;
  logic [1:0]  op;
  logic        signed_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_hilo;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        en_reg;

  int          errors;
  int          checks;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  muldiv_hilo_unit #(
    .WIDTH(32),
    .CNT_W(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .signed_op (signed_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_hilo   (rd_hilo),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .en_reg    (en_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic s, output logic [31:0] eh, output logic [31:0] el);
    longint      sa;
    longint      sb;
    longint      sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == T_MULT) begin
      if (s) begin
        sp = sa * sb;
        up = 64'(sp);
      end else begin
        up = {32'd0, a} * {32'd0, b};
      end
      eh = up[63:32];
      el = up[31:0];
    end else if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (s) begin
      el = 32'(sa / sb);
      eh = 32'(sa % sb);
    end else begin
      el = a / b;
      eh = a % b;
    end
  endtask

  // Presents one op in the current cycle, then a follow-up instruction:
  // 0 none, 1 MFHI/MFLO, 2 MTLO, 3 MTHI (data = fdata). Returns in the
  // cycle after FIX (or after the follow-up write completes).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int follow, input logic [31:0] fdata);
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] ph;
    logic [31:0] pl;
    logic        s_eff;
    logic        fuse;
    int          lat;
`ifdef MULDIV_SIGNED_EN
    s_eff = s;
`else
    s_eff = 1'b0;
`endif
    model(o, a, b, s_eff, eh, el);
    lat  = (o == T_DIV && b == 32'd0) ? 1 : 33;
    ph   = model_hi;
    pl   = model_lo;
    fuse = (follow != 0);
    op = o; src_a = a; src_b = b; signed_op = s;
    #1;
    check("accept_en", en_reg, 1);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        op = 2'b00; signed_op = 1'($urandom); src_a = fdata; src_b = $urandom;
        rd_hilo = (follow == 1); wr_lo = (follow == 2); wr_hi = (follow == 3);
      end
      #1;
      check($sformatf("busy@%0d", k), busy, (k <= lat));
      check($sformatf("done@%0d", k), done, (k == lat));
      check($sformatf("en_reg@%0d", k), en_reg, !((k <= lat) && fuse));
      if (k == lat) begin
        check("hi_hold", hi, ph);
        check("lo_hold", lo, pl);
      end
    end
    check($sformatf("hi op=%0d a=%0h b=%0h s=%0d", o, a, b, s_eff), hi, eh);
    check($sformatf("lo op=%0d a=%0h b=%0h s=%0d", o, a, b, s_eff), lo, el);
    model_hi = eh;
    model_lo = el;
    if (follow >= 2) begin
      @(negedge clk);
      rd_hilo = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
      #1;
      if (follow == 2) model_lo = fdata;
      else model_hi = fdata;
      check("follow_hi", hi, model_hi);
      check("follow_lo", lo, model_lo);
    end else begin
      rd_hilo = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    errors = 0; checks = 0;
    model_hi = '0; model_lo = '0;
    reset = 1'b1; op = 2'b00; signed_op = 1'b0; src_a = '0; src_b = '0;
    rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", en_reg, 1);
    reset = 1'b0;

    // MTHI alone, then MTHI+MTLO together while idle.
    wr_hi = 1'b1; src_a = 32'h1234;
    @(negedge clk); #1;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 0);
    wr_lo = 1'b1; src_a = 32'hABCD_0001;
    @(negedge clk); #1;
    check("mtboth_hi", hi, 32'hABCD_0001);
    check("mtboth_lo", lo, 32'hABCD_0001);
    wr_hi = 1'b0; wr_lo = 1'b0;
    model_hi = 32'hABCD_0001; model_lo = 32'hABCD_0001;

    run_op(T_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'h0);
    check("mult_max_hi", hi, 32'hFFFF_FFFE);
    check("mult_max_lo", lo, 32'h0000_0001);
    // Back-to-back: each next op is presented in the cycle after FIX.
    run_op(T_DIV, 32'd100, 32'd7, 1'b0, 0, 32'h0);
    check("div_100_7_hi", hi, 32'd2);
    check("div_100_7_lo", lo, 32'd14);
    run_op(T_DIV, 32'd5, 32'd0, 1'b0, 0, 32'h0);
    check("div0_hi", hi, 32'd5);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    run_op(T_MULT, 32'd3, 32'd5, 1'b0, 1, 32'h0);
    check("mult_3_5_lo", lo, 32'd15);
    run_op(T_MULT, 32'd7, 32'd9, 1'b0, 2, 32'h5555_AAAA);
    check("mtlo_after_lo", lo, 32'h5555_AAAA);

    // Reset at RUN cycle 10 discards the op.
    op = T_MULT; src_a = $urandom; src_b = $urandom;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      op = 2'b00;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rd_hilo = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_done", done, 0);
    check("midrst_en", en_reg, 1);
    rd_hilo = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk); #1;
    check("midrst_idle", busy, 0);
    run_op(T_MULT, 32'd2, 32'd2, 1'b0, 0, 32'h0);
    check("mult_2_2_lo", lo, 32'd4);

`ifdef MULDIV_SIGNED_EN
    run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'h0);
    check("sdiv_lo", lo, 32'hFFFF_FFFD);
    check("sdiv_hi", hi, 32'hFFFF_FFFF);
    run_op(T_MULT, 32'hFFFF_FFFD, 32'd4, 1'b1, 0, 32'h0);
    check("smult_hi", hi, 32'hFFFF_FFFF);
    check("smult_lo", lo, 32'hFFFF_FFF4);
`endif

    for (int i = 0; i < 24; i++) begin
      o = ($urandom_range(1, 0) == 1) ? T_MULT : T_DIV;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(3, 0) == 0) b = b >> $urandom_range(31, 0);
      if ($urandom_range(7, 0) == 0) b = 32'd0;
      run_op(o, a, b, 1'($urandom), int'($urandom_range(3, 0)), $urandom);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
